chess_turn_ctrl: RTL and testbench
==================================

# chess_turn_ctrl

Turn controller for the chess timer. It sequences the two per-player `countDown` instances: it decides which player's timer runs, routes minute-setting pulses during setup, freezes both timers on pause, and latches a flag when a player runs out of time. It sits between the debounced front-panel buttons and the two timer datapaths. It also drives the turn and flag indicators.

## Interface
Parameters:
- none

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `btn_p1`  in  1  player 1 move button; debounced level.
- `btn_p2`  in  1  player 2 move button; debounced level.
- `btn_pause`  in  1  pause/resume button; debounced level.
- `btn_set`  in  1  setup mode toggle; debounced level.
- `btn_min`  in  1  add-minute button; debounced level.
- `p1_zero`  in  1  level from timer 1: its count is 0:00.
- `p2_zero`  in  1  level from timer 2: its count is 0:00.
- `en_p1`  out  1  enable to timer 1.
- `en_p2`  out  1  enable to timer 2.
- `set_out`  out  1  set-mode to both timers.
- `min_out`  out  1  one-cycle minute-increment pulse to both timers.
- `stop_out`  out  1  hold to both timers while paused.
- `turn`  out  2  `01` = P1 running, `10` = P2 running, `00` = otherwise.
- `flag_p1`  out  1  P1 lost on time.
- `flag_p2`  out  1  P2 lost on time.
- `move_count`  out  8  half-move count; present only with `MOVE_COUNTER_EN`.

## Operation
- Every button has an edge detector. A press is a cycle where the button is 1 and was 0 on the previous cycle.
- Holding a button produces exactly one press. Press history is cleared by `rst`, so a button held high through reset produces no press.
- FSM states: SETUP, READY, RUN_P1, RUN_P2, PAUSED, FLAG. A 1-bit `resume` register records which player to resume after a pause.
- SETUP (the reset state):
  - `set_out`=1.
  - `btn_min` press → `min_out` pulses.
  - `btn_set` press → READY.
  - All other buttons are ignored.
- READY:
  - All timer controls are 0.
  - `btn_p2` press → RUN_P1. Player 2 starts White's clock.
  - `btn_set` press → SETUP.
  - `btn_p1` and `btn_pause` are ignored.
- RUN_P1, in priority order:
  - `p1_zero`=1 → FLAG with `flag_p1` set.
  - else `btn_pause` press → PAUSED, with `resume`=P1.
  - else `btn_p1` press → RUN_P2.
  - `btn_p2`, `btn_set` and `btn_min` are ignored.
- RUN_P2 mirrors RUN_P1 with the players swapped.
- PAUSED:
  - `stop_out`=1 and both enables are 0.
  - `btn_pause` press → RUN_P1 or RUN_P2 according to `resume`.
  - else `btn_set` press → SETUP.
  - Move buttons are ignored.
- FLAG:
  - Both enables are 0. `flag_pN` holds.
  - Only `btn_set` press (→ SETUP, both flags cleared) or `rst` exits.
- Output decode: `en_p1`=1 only in RUN_P1, `en_p2`=1 only in RUN_P2, `set_out`=1 only in SETUP, `stop_out`=1 only in PAUSED.
- Simultaneous move presses in a RUN state: only the running player's button counts.

## Timing
- Values after reset: `set_out`=1; `en_p1`, `en_p2`, `min_out`, `stop_out`, `flag_p1`, `flag_p2` all 0; `turn`=`00`; `move_count`=0.
- Enables, `set_out`, `stop_out` and `turn` are Moore decodes of the state register. A press sampled at edge k changes them right after edge k (1-cycle latency from the input rising).
- `min_out` is registered. A press sampled at edge k gives a pulse exactly one cycle wide, high between edges k and k+1.
- `p1_zero`/`p2_zero` are sampled every cycle in the matching RUN state. Flag latency is 1 cycle.
- `rst` mid-game returns to SETUP at the next edge regardless of state. It clears the flags and `move_count`.

## Configuration
- `MOVE_COUNTER_EN` defined:
  - 8-bit `move_count` port and register exist.
  - Increments on each accepted RUN_P1↔RUN_P2 handoff; the start from READY does not count.
  - Saturates at 255.
  - Cleared on entry to SETUP and on `rst`.
- Not defined: port and register are absent. All other behaviour is identical.

## Test plan
- Reset, hold `btn_min` high 5 cycles then release, repeat twice → exactly 2 one-cycle `min_out` pulses; `set_out`=1 throughout.
- `btn_set` press, then `btn_p2` press → `en_p1`=1 and `turn`=`01` one cycle after the press edge. Then `btn_p1` and `btn_p2` pressed in the same cycle → RUN_P2, `turn`=`10`.
- In RUN_P2: `btn_pause` press → `stop_out`=1 and both enables 0. Second `btn_pause` press → `en_p2`=1 again.
- In RUN_P1, raise `p1_zero` in the same cycle as a `btn_p1` press → FLAG with `flag_p1`=1, not RUN_P2. Move buttons are then ignored; `btn_set` press → SETUP with flags cleared.
- With `MOVE_COUNTER_EN`: 300 alternating handoffs → `move_count`=255. `rst` → 0.
- Assert `rst` during RUN_P1 → next cycle `set_out`=1, `en_p1`=0, `turn`=`00`.

Source files
------------

// File: rtl/chess_turn_ctrl.sv
// Turn controller for a two-player chess timer: button edge detection, game FSM,
// timer enables and loss-on-time flags. Optional half-move counter: MOVE_COUNTER_EN.
module chess_turn_ctrl (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_p1,
   input  logic       btn_p2,
   input  logic       btn_pause,
   input  logic       btn_set,
   input  logic       btn_min,
   input  logic       p1_zero,
   input  logic       p2_zero,
   output logic       en_p1,
   output logic       en_p2,
   output logic       set_out,
   output logic       min_out,
   output logic       stop_out,
   output logic [1:0] turn,
   output logic       flag_p1,
   output logic       flag_p2
`ifdef MOVE_COUNTER_EN
   ,
   output logic [7:0] move_count
`endif
);

   typedef enum logic [2:0] {
      ST_SETUP   = 3'd0,
      ST_READY   = 3'd1,
      ST_RUN_P1  = 3'd2,
      ST_RUN_P2  = 3'd3,
      ST_PAUSED  = 3'd4,
      ST_FLAG    = 3'd5
   } state_t;

   localparam int B_P1    = 0;
   localparam int B_P2    = 1;
   localparam int B_PAUSE = 2;
   localparam int B_SET   = 3;
   localparam int B_MIN   = 4;

   state_t     state_q, state_d;
   logic       resume_q, resume_d;   // 0: resume P1, 1: resume P2
   logic       flag_p1_q, flag_p1_d;
   logic       flag_p2_q, flag_p2_d;
   logic       min_q, min_d;
   logic [4:0] btn_q;
   logic [4:0] btn_now;
   logic [4:0] press;
   logic       handoff;

`ifdef MOVE_COUNTER_EN
   logic [7:0] cnt_q, cnt_d;
`endif

   assign btn_now = {btn_min, btn_set, btn_pause, btn_p2, btn_p1};
   assign press   = btn_now & ~btn_q;

   // Button history tracks the live level, also while rst is high, so a button
   // held through reset never produces a press.
   always_ff @(posedge clk) begin
      btn_q <= btn_now;
      if (rst) begin
         state_q   <= ST_SETUP;
         resume_q  <= 1'b0;
         flag_p1_q <= 1'b0;
         flag_p2_q <= 1'b0;
         min_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         resume_q  <= resume_d;
         flag_p1_q <= flag_p1_d;
         flag_p2_q <= flag_p2_d;
         min_q     <= min_d;
      end
   end

`ifdef MOVE_COUNTER_EN
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= 8'd0;
      else     cnt_q <= cnt_d;
   end
`endif

   always_comb begin
      state_d   = state_q;
      resume_d  = resume_q;
      flag_p1_d = flag_p1_q;
      flag_p2_d = flag_p2_q;
      min_d     = 1'b0;
      handoff   = 1'b0;
      case (state_q)
         ST_SETUP: begin
            min_d = press[B_MIN];
            if (press[B_SET]) state_d = ST_READY;
         end
         ST_READY: begin
            if (press[B_P2])       state_d = ST_RUN_P1;
            else if (press[B_SET]) state_d = ST_SETUP;
         end
         ST_RUN_P1: begin
            // Time-out wins over any button seen in the same cycle.
            if (p1_zero) begin
               state_d   = ST_FLAG;
               flag_p1_d = 1'b1;
            end else if (press[B_PAUSE]) begin
               state_d  = ST_PAUSED;
               resume_d = 1'b0;
            end else if (press[B_P1]) begin
               state_d = ST_RUN_P2;
               handoff = 1'b1;
            end
         end
         ST_RUN_P2: begin
            if (p2_zero) begin
               state_d   = ST_FLAG;
               flag_p2_d = 1'b1;
            end else if (press[B_PAUSE]) begin
               state_d  = ST_PAUSED;
               resume_d = 1'b1;
            end else if (press[B_P2]) begin
               state_d = ST_RUN_P1;
               handoff = 1'b1;
            end
         end
         ST_PAUSED: begin
            if (press[B_PAUSE])    state_d = resume_q ? ST_RUN_P2 : ST_RUN_P1;
            else if (press[B_SET]) state_d = ST_SETUP;
         end
         ST_FLAG: begin
            if (press[B_SET]) begin
               state_d   = ST_SETUP;
               flag_p1_d = 1'b0;
               flag_p2_d = 1'b0;
            end
         end
         default: state_d = ST_SETUP;
      endcase
   end

`ifdef MOVE_COUNTER_EN
   always_comb begin
      cnt_d = cnt_q;
      if (state_d == ST_SETUP && state_q != ST_SETUP) cnt_d = 8'd0;
      else if (handoff && cnt_q != 8'hFF)             cnt_d = cnt_q + 8'd1;
   end
   assign move_count = cnt_q;
`else
   logic unused_handoff;
   assign unused_handoff = handoff;
`endif

   always_comb begin
      en_p1    = (state_q == ST_RUN_P1);
      en_p2    = (state_q == ST_RUN_P2);
      set_out  = (state_q == ST_SETUP);
      stop_out = (state_q == ST_PAUSED);
      turn     = {en_p2, en_p1};
      min_out  = min_q;
      flag_p1  = flag_p1_q;
      flag_p2  = flag_p2_q;
   end

endmodule

// File: tb/tb_chess_turn_ctrl.sv
// Directed self-checking bench for chess_turn_ctrl; the move-counter section
// is compiled only when MOVE_COUNTER_EN is defined.
module tb_chess_turn_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       btn_p1, btn_p2, btn_pause, btn_set, btn_min;
   logic       p1_zero, p2_zero;
   logic       en_p1, en_p2, set_out, min_out, stop_out;
   logic [1:0] turn;
   logic       flag_p1, flag_p2;
`ifdef MOVE_COUNTER_EN
   logic [7:0] move_count;
`endif

   localparam logic [4:0] B_NONE  = 5'b00000;
   localparam logic [4:0] B_P1    = 5'b00001;
   localparam logic [4:0] B_P2    = 5'b00010;
   localparam logic [4:0] B_PAUSE = 5'b00100;
   localparam logic [4:0] B_SET   = 5'b01000;
   localparam logic [4:0] B_MIN   = 5'b10000;

   int num_checks = 0;
   int num_errors = 0;

   chess_turn_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .btn_p1    (btn_p1),
      .btn_p2    (btn_p2),
      .btn_pause (btn_pause),
      .btn_set   (btn_set),
      .btn_min   (btn_min),
      .p1_zero   (p1_zero),
      .p2_zero   (p2_zero),
      .en_p1     (en_p1),
      .en_p2     (en_p2),
      .set_out   (set_out),
      .min_out   (min_out),
      .stop_out  (stop_out),
      .turn      (turn),
      .flag_p1   (flag_p1),
      .flag_p2   (flag_p2)
`ifdef MOVE_COUNTER_EN
      ,
      .move_count(move_count)
`endif
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      num_checks++;
      if (got !== exp) begin
         num_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_btns(input logic [4:0] v);
      {btn_min, btn_set, btn_pause, btn_p2, btn_p1} = v;
   endtask

   // One idle edge with buttons low, then the press edge; outputs are sampled after it.
   task automatic press(input logic [4:0] v);
      step();
      set_btns(v);
      step();
      set_btns(B_NONE);
   endtask

   initial begin
      int pulses;
      int set_bad;
      rst = 1'b1;
      p1_zero = 1'b0;
      p2_zero = 1'b0;
      set_btns(B_SET);
      repeat (3) step();
      rst = 1'b0;
      step();
      step();
      check("held_set_no_press", set_out, 1'b1);
      check("rst_en_p1", en_p1, 1'b0);
      check("rst_en_p2", en_p2, 1'b0);
      check("rst_min", min_out, 1'b0);
      check("rst_stop", stop_out, 1'b0);
      check("rst_flags", {flag_p1, flag_p2}, 2'b00);
      check("rst_turn", turn, 2'b00);
`ifdef MOVE_COUNTER_EN
      check("rst_count", move_count, 8'd0);
`endif
      set_btns(B_NONE);
      step();

      pulses  = 0;
      set_bad = 0;
      for (int rep = 0; rep < 2; rep++) begin
         set_btns(B_MIN);
         for (int i = 0; i < 5; i++) begin
            step();
            if (min_out) pulses++;
            if (!set_out) set_bad++;
            if (rep == 0 && i == 0) check("min_first_cycle", min_out, 1'b1);
            if (rep == 0 && i == 1) check("min_second_cycle", min_out, 1'b0);
         end
         set_btns(B_NONE);
         for (int i = 0; i < 3; i++) begin
            step();
            if (min_out) pulses++;
            if (!set_out) set_bad++;
         end
      end
      check("min_pulses", pulses, 2);
      check("set_out_hold", set_bad, 0);

      press(B_SET);
      check("ready_set_out", set_out, 1'b0);
      check("ready_turn", turn, 2'b00);
      press(B_P1);
      check("ready_ign_p1", turn, 2'b00);
      press(B_PAUSE);
      check("ready_ign_pause", stop_out, 1'b0);
      p1_zero = 1'b1;
      step();
      check("ready_ign_zero", flag_p1, 1'b0);
      p1_zero = 1'b0;

      press(B_P2);
      check("start_en_p1", en_p1, 1'b1);
      check("start_turn", turn, 2'b01);
      press(B_P1 | B_P2);
      check("hand_turn", turn, 2'b10);
      check("hand_en", {en_p2, en_p1}, 2'b10);

      press(B_PAUSE);
      check("pause_stop", stop_out, 1'b1);
      check("pause_en", {en_p2, en_p1}, 2'b00);
      check("pause_turn", turn, 2'b00);
      press(B_P2);
      check("pause_ign_move", stop_out, 1'b1);
      press(B_PAUSE);
      check("resume_en_p2", en_p2, 1'b1);
      check("resume_stop", stop_out, 1'b0);

      press(B_P2);
      check("back_p1", turn, 2'b01);
      step();
      p1_zero = 1'b1;
      set_btns(B_P1);
      step();
      set_btns(B_NONE);
      check("flag_p1", flag_p1, 1'b1);
      check("flag_en", {en_p2, en_p1}, 2'b00);
      check("flag_turn", turn, 2'b00);
      p1_zero = 1'b0;
      press(B_P1 | B_P2);
      check("flag_ign_moves", {flag_p1, en_p2, en_p1}, 3'b100);
      press(B_SET);
      check("flag_exit_set", set_out, 1'b1);
      check("flag_cleared", {flag_p1, flag_p2}, 2'b00);

      press(B_SET);
      press(B_P2);
      press(B_P1);
      check("p2_running", turn, 2'b10);
      p2_zero = 1'b1;
      step();
      check("flag_p2", {flag_p1, flag_p2}, 2'b01);
      p2_zero = 1'b0;
      press(B_SET);
      check("flag_p2_cleared", flag_p2, 1'b0);

      press(B_SET);
      press(B_P2);
      press(B_PAUSE);
      check("pause_p1_stop", stop_out, 1'b1);
      press(B_PAUSE);
      check("resume_p1", turn, 2'b01);
      press(B_PAUSE);
      press(B_SET);
      check("pause_to_setup", set_out, 1'b1);

      press(B_SET);
      press(B_P2);
      check("pre_rst_run", en_p1, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_set", set_out, 1'b1);
      check("midrst_en_p1", en_p1, 1'b0);
      check("midrst_turn", turn, 2'b00);

`ifdef MOVE_COUNTER_EN
      press(B_SET);
      press(B_P2);
      check("cnt_start", move_count, 8'd0);
      for (int i = 0; i < 150; i++) begin
         press(B_P1);
         if (i == 0) check("cnt_first", move_count, 8'd1);
         press(B_P2);
      end
      check("cnt_sat", move_count, 8'd255);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("cnt_rst", move_count, 8'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
      $finish;
   end

endmodule
